// File: rtl/systolic_feeder_if.sv
// Host/array-facing bundle of systolic_feeder: load stream, skewed array operands,
// array accumulators and the result stream.
interface systolic_feeder_if #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int PW = 32
);
  logic                          ld_valid;
  logic                          ld_ready;
  logic [DW-1:0]                 ld_data;
  logic                          arr_rst;
  logic [N-1:0][DW-1:0]          A_in;
  logic [N-1:0][DW-1:0]          B_in;
  logic [N-1:0][N-1:0][PW-1:0]   C_arr;
  logic                          res_valid;
  logic                          res_ready;
  logic [PW-1:0]                 res_data;
  logic                          busy;

  modport slave (
    input  ld_valid, ld_data, C_arr, res_ready,
    output ld_ready, arr_rst, A_in, B_in, res_valid, res_data, busy
  );

  modport master (
    output ld_valid, ld_data, C_arr, res_ready,
    input  ld_ready, arr_rst, A_in, B_in, res_valid, res_data, busy
  );
endinterface

// File: rtl/systolic_feeder.sv
// Load/skew/drain/capture sequencer in front of an NxN systolic array.
// Define SYSTOLIC_FEEDER_BCOLMAJOR_EN to accept the B half of the load stream column-major.
module systolic_feeder #(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int PW    = 32,
  parameter int DRAIN = N + 2
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  bus
);
  localparam int NN = N * N;
  localparam int MW = $clog2(2 * NN);
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int TW = $clog2(2 * N + DRAIN) + 1;

  typedef enum logic [2:0] {
    ST_LOAD, ST_CLEAR, ST_FEED, ST_DRAIN, ST_CAPTURE, ST_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] k_q, k_d;
  logic [TW-1:0] t_q, t_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] mem_q [2*NN];
  logic [PW-1:0] res_buf_q [NN];
  logic          ld_fire, res_fire;
  int            step_d;

  assign bus.ld_ready  = (state_q == ST_LOAD) && !rst;
  assign bus.res_valid = (state_q == ST_OUT) && !rst;
  assign bus.res_data  = (state_q == ST_OUT) ? res_buf_q[idx_q] : '0;
  assign bus.busy      = (state_q != ST_LOAD) && !rst;
  assign bus.arr_rst   = rst || (state_q == ST_CLEAR);

  assign ld_fire  = bus.ld_valid && bus.ld_ready;
  assign res_fire = bus.res_valid && bus.res_ready;
  assign step_d   = int'(t_d);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_LOAD: begin
        if (ld_fire) begin
          if (k_q == MW'(2 * NN - 1)) begin
            k_d     = '0;
            state_d = ST_CLEAR;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        t_d     = '0;
        state_d = ST_FEED;
      end
      // t counts feed steps here and is reused as the drain counter afterwards
      ST_FEED: begin
        if (t_q == TW'(2 * N - 2)) begin
          t_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (t_q == TW'(DRAIN - 1)) begin
          t_d     = '0;
          state_d = ST_CAPTURE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        idx_d   = '0;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (res_fire) begin
          if (idx_q == IW'(NN - 1)) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      k_q     <= '0;
      t_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
    end
  end

  // Operand store needs no reset: k restarts at 0 and every word is rewritten before use.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem_q[k_q] <= bus.ld_data;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        always_ff @(posedge clk) begin
          if (rst) begin
            res_buf_q[gi*N+gj] <= '0;
          end else if (state_q == ST_CAPTURE) begin
            res_buf_q[gi*N+gj] <= bus.C_arr[gi][gj];
          end
        end
      end
    end

    // Lane gi carries row gi of A and column gi of B, delayed by gi steps.
    // The registers are loaded with the step about to be entered so they show step t during it.
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] a_d, b_d, a_q, b_q;

      always_comb begin
        a_d = '0;
        b_d = '0;
        if (state_d == ST_FEED && step_d >= gi && step_d - gi < N) begin
          a_d = mem_q[MW'(gi * N + step_d - gi)];
`ifdef SYSTOLIC_FEEDER_BCOLMAJOR_EN
          b_d = mem_q[MW'(NN + gi * N + step_d - gi)];
`else
          b_d = mem_q[MW'(NN + (step_d - gi) * N + gi)];
`endif
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign bus.A_in[gi] = a_q;
      assign bus.B_in[gi] = b_q;
    end
  endgenerate
endmodule
